multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Shared-memory handshake between the multi-cycle control FSM and the memory port.
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_we_o;
    logic i_or_d_o;
    logic mem_ready_i;

    modport master (output mem_req_o, output mem_we_o, output i_or_d_o, input mem_ready_i);
    modport slave  (input mem_req_o, input mem_we_o, input i_or_d_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with variable-latency memory handshake, illegal-opcode and memory-timeout traps.
//  state        | meaning
//  0 FETCH      | read instr at PC, PC+4      1 DECODE   | branch target to ALUOut, dispatch
//  2 MEM_ADDR   | rs+imm address              3 MEM_RD   | load read     4 MEM_WB | load writeback
//  5 MEM_WR     | store write                 6 EXEC_R   | R-type ALU    7 WB_R   | rd writeback
//  8 EXEC_I     | addi ALU                    9 WB_I     | rt writeback  10 BRANCH | beq/bne
//  11 JUMP      | PC <- jump target           15 FAULT   | trapped, waits for reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int RET_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               zero_i,
    multicycle_ctrl_if.master  mem,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         ALUOp_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic               timeout_o,
    output logic [RET_W-1:0]   retired_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [RET_W-1:0]   r_retired;
    logic               r_illegal;
    logic               r_timeout;

    logic               w_mem_req;
    logic               w_mem_we;
    logic               w_i_or_d;
    logic               w_ir_write;
    logic               w_pc_write;
    logic [1:0]         w_pc_src;
    logic               w_reg_write;
    logic               w_reg_dst;
    logic               w_mem_to_reg;
    logic               w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [2:0]         w_alu_op;
    logic               w_retire;
    logic               w_set_illegal;
    logic               w_set_timeout;
    logic               w_expired;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // Down-counter reaches zero on wait cycle MEM_TIMEOUT; a ready on that cycle still wins.
    assign w_expired = (r_wait_cnt == '0) && !mem.mem_ready_i;

    always_comb begin
        w_state_next  = r_state;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_i_or_d      = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 2'b00;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 3'b000;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem.mem_ready_i) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = S_FAULT;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode_i)
                    6'b000000:            w_state_next = S_EXEC_R;
                    6'b001000:            w_state_next = S_EXEC_I;
                    6'b100011, 6'b101011: w_state_next = S_MEM_ADDR;
                    6'b000100, 6'b000101: w_state_next = S_BRANCH;
                    6'b000010:            w_state_next = S_JUMP;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_state_next  = S_FAULT;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_state_next = opcode_i[3] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
                if (mem.mem_ready_i) begin
                    w_state_next = S_MEM_WB;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = S_FAULT;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_i_or_d  = 1'b1;
                if (mem.mem_ready_i) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = S_FAULT;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 3'b010;
                w_state_next = S_WB_R;
            end
            S_WB_R: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_alu_op     = 3'b100;
                w_state_next = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                // opcode bit 0 separates bne (000101) from beq (000100)
                w_alu_src_a  = 1'b1;
                w_pc_src     = 2'b01;
                w_alu_op     = opcode_i[0] ? 3'b110 : 3'b001;
                w_pc_write   = opcode_i[0] ? ~zero_i : zero_i;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= CNT_LOAD;
            r_retired  <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (is_mem_state(w_state_next) && (w_state_next != r_state)) begin
                r_wait_cnt <= CNT_LOAD;
            end else if (is_mem_state(r_state) && !mem.mem_ready_i && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + RET_W'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Every output is forced low while reset is being sampled.
    assign mem.mem_req_o = w_mem_req    & ~rst_i;
    assign mem.mem_we_o  = w_mem_we     & ~rst_i;
    assign mem.i_or_d_o  = w_i_or_d     & ~rst_i;
    assign ir_write_o    = w_ir_write   & ~rst_i;
    assign pc_write_o    = w_pc_write   & ~rst_i;
    assign pc_src_o      = rst_i ? 2'b00 : w_pc_src;
    assign reg_write_o   = w_reg_write  & ~rst_i;
    assign reg_dst_o     = w_reg_dst    & ~rst_i;
    assign mem_to_reg_o  = w_mem_to_reg & ~rst_i;
    assign alu_src_a_o   = w_alu_src_a  & ~rst_i;
    assign alu_src_b_o   = rst_i ? 2'b00 : w_alu_src_b;
    assign ALUOp_o       = rst_i ? 3'b000 : w_alu_op;
    assign state_o       = rst_i ? 4'd0 : r_state;
    assign illegal_o     = r_illegal & ~rst_i;
    assign timeout_o     = r_timeout & ~rst_i;
    assign retired_o     = rst_i ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (MEM_TIMEOUT=4, RET_W=4 to reach wrap quickly).
module tb_multicycle_ctrl;

    localparam int RW = 4;

    localparam logic [3:0] FE = 4'd0,  DE = 4'd1,  MA = 4'd2,  MR = 4'd3,  MB = 4'd4;
    localparam logic [3:0] MW = 4'd5,  XR = 4'd6,  WR = 4'd7,  XI = 4'd8,  WI = 4'd9;
    localparam logic [3:0] BR = 4'd10, JP = 4'd11, FT = 4'd15;

    // {mem_req,mem_we,i_or_d, ir_write,pc_write,pc_src, reg_write,reg_dst,mem_to_reg, alu_a,alu_b,aluop}
    localparam logic [15:0] C_ZERO   = 16'h0000;
    localparam logic [15:0] C_FE_W   = {1'b1,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b0,2'b01,3'b000};
    localparam logic [15:0] C_FE_R   = {1'b1,1'b0,1'b0, 1'b1,1'b1,2'b00, 1'b0,1'b0,1'b0, 1'b0,2'b01,3'b000};
    localparam logic [15:0] C_DE     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b0,2'b11,3'b000};
    localparam logic [15:0] C_MA     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b1,2'b10,3'b000};
    localparam logic [15:0] C_MR     = {1'b1,1'b0,1'b1, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b0,2'b00,3'b000};
    localparam logic [15:0] C_MB     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b1,1'b0,1'b1, 1'b0,2'b00,3'b000};
    localparam logic [15:0] C_MW     = {1'b1,1'b1,1'b1, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b0,2'b00,3'b000};
    localparam logic [15:0] C_XR     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b1,2'b00,3'b010};
    localparam logic [15:0] C_WR     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0, 1'b0,2'b00,3'b000};
    localparam logic [15:0] C_XI     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0, 1'b1,2'b10,3'b100};
    localparam logic [15:0] C_WI     = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b00, 1'b1,1'b0,1'b0, 1'b0,2'b00,3'b000};
    localparam logic [15:0] C_BEQ_T  = {1'b0,1'b0,1'b0, 1'b0,1'b1,2'b01, 1'b0,1'b0,1'b0, 1'b1,2'b00,3'b001};
    localparam logic [15:0] C_BEQ_N  = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0, 1'b1,2'b00,3'b001};
    localparam logic [15:0] C_BNE_T  = {1'b0,1'b0,1'b0, 1'b0,1'b1,2'b01, 1'b0,1'b0,1'b0, 1'b1,2'b00,3'b110};
    localparam logic [15:0] C_BNE_N  = {1'b0,1'b0,1'b0, 1'b0,1'b0,2'b01, 1'b0,1'b0,1'b0, 1'b1,2'b00,3'b110};
    localparam logic [15:0] C_JP     = {1'b0,1'b0,1'b0, 1'b0,1'b1,2'b10, 1'b0,1'b0,1'b0, 1'b0,2'b00,3'b000};

    typedef struct packed {
        logic [3:0]    st;
        logic [15:0]   ctl;
        logic          ill;
        logic          to;
        logic [RW-1:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic          zero;
    logic          ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    aluop;
    logic [3:0]    state;
    logic          illegal, timeout;
    logic [RW-1:0] retired;
    logic [15:0]   w_ctl;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic          exp_ill;
    logic          exp_to;
    logic [RW-1:0] exp_ret;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .RET_W(RW)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero), .mem(mif),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
        .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .ALUOp_o(aluop),
        .state_o(state), .illegal_o(illegal), .timeout_o(timeout), .retired_o(retired)
    );

    always #5 clk = ~clk;

    assign w_ctl = {mif.mem_req_o, mif.mem_we_o, mif.i_or_d_o, ir_write, pc_write, pc_src,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluop};

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        assert (state === e.st) else begin
            errors++; $error("FAIL %s state got %0d exp %0d", tag, state, e.st);
        end
        checks++;
        assert (w_ctl === e.ctl) else begin
            errors++; $error("FAIL %s ctrl got %b exp %b", tag, w_ctl, e.ctl);
        end
        checks++;
        assert (illegal === e.ill) else begin
            errors++; $error("FAIL %s illegal got %b exp %b", tag, illegal, e.ill);
        end
        checks++;
        assert (timeout === e.to) else begin
            errors++; $error("FAIL %s timeout got %b exp %b", tag, timeout, e.to);
        end
        checks++;
        assert (retired === e.ret) else begin
            errors++; $error("FAIL %s retired got %0d exp %0d", tag, retired, e.ret);
        end
    endtask

    // One clock: push the expectation, drive inputs, compare on the falling edge.
    task automatic step(input string tag, input logic r, input logic rdy, input logic z,
                        input logic [3:0] es, input logic [15:0] ec);
        exp_t e;
        e.st  = es;
        e.ctl = ec;
        e.ill = r ? 1'b0 : exp_ill;
        e.to  = r ? 1'b0 : exp_to;
        e.ret = r ? '0 : exp_ret;
        sb.push_back(e);
        rst = r;
        mif.mem_ready_i = rdy;
        zero = z;
        @(negedge clk);
        check_out(tag);
        @(posedge clk);
        #1;
        if (r) begin
            exp_ill = 1'b0;
            exp_to  = 1'b0;
            exp_ret = '0;
        end
    endtask

    task automatic do_jump(input string tag);
        opcode = 6'b000010;
        step(tag, 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step(tag, 1'b0, 1'b1, 1'b0, DE, C_DE);
        step(tag, 1'b0, 1'b1, 1'b0, JP, C_JP);
        exp_ret++;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; mif.mem_ready_i = 1'b0;
        exp_ill = 1'b0; exp_to = 1'b0; exp_ret = '0;
        @(posedge clk);
        #1;
        step("reset", 1'b1, 1'b1, 1'b0, FE, C_ZERO);
        step("reset", 1'b1, 1'b1, 1'b0, FE, C_ZERO);

        opcode = 6'b000000;
        step("add", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("add", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("add", 1'b0, 1'b1, 1'b0, XR, C_XR);
        step("add", 1'b0, 1'b1, 1'b0, WR, C_WR);
        exp_ret++;

        opcode = 6'b100011;
        step("lw", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("lw", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("lw", 1'b0, 1'b1, 1'b0, MA, C_MA);
        for (int i = 0; i < 3; i++) step("lw_wait", 1'b0, 1'b0, 1'b0, MR, C_MR);
        step("lw_rdy", 1'b0, 1'b1, 1'b0, MR, C_MR);
        step("lw", 1'b0, 1'b0, 1'b0, MB, C_MB);
        exp_ret++;

        opcode = 6'b101011;
        step("sw", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("sw", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("sw", 1'b0, 1'b1, 1'b0, MA, C_MA);
        step("sw", 1'b0, 1'b1, 1'b0, MW, C_MW);
        exp_ret++;

        opcode = 6'b001000;
        step("addi", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("addi", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("addi", 1'b0, 1'b1, 1'b0, XI, C_XI);
        step("addi", 1'b0, 1'b1, 1'b0, WI, C_WI);
        exp_ret++;

        opcode = 6'b000100;
        step("beq_t", 1'b0, 1'b1, 1'b1, FE, C_FE_R);
        step("beq_t", 1'b0, 1'b1, 1'b1, DE, C_DE);
        step("beq_t", 1'b0, 1'b1, 1'b1, BR, C_BEQ_T);
        exp_ret++;
        step("beq_n", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("beq_n", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("beq_n", 1'b0, 1'b1, 1'b0, BR, C_BEQ_N);
        exp_ret++;

        opcode = 6'b000101;
        step("bne_t", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("bne_t", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("bne_t", 1'b0, 1'b1, 1'b0, BR, C_BNE_T);
        exp_ret++;
        step("bne_n", 1'b0, 1'b1, 1'b1, FE, C_FE_R);
        step("bne_n", 1'b0, 1'b1, 1'b1, DE, C_DE);
        step("bne_n", 1'b0, 1'b1, 1'b1, BR, C_BNE_N);
        exp_ret++;

        do_jump("j");

        // ready arrives on the last allowed wait cycle of FETCH
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) step("fe_late", 1'b0, 1'b0, 1'b0, FE, C_FE_W);
        step("fe_late_rdy", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("fe_late", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("fe_late", 1'b0, 1'b1, 1'b0, JP, C_JP);
        exp_ret++;

        for (int i = 0; i < 6; i++) do_jump("wrap");

        opcode = 6'b101011;
        step("sw_rst", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("sw_rst", 1'b0, 1'b1, 1'b0, DE, C_DE);
        step("sw_rst", 1'b0, 1'b1, 1'b0, MA, C_MA);
        step("sw_rst_wait", 1'b0, 1'b0, 1'b0, MW, C_MW);
        step("sw_rst_wait", 1'b0, 1'b0, 1'b0, MW, C_MW);
        step("sw_rst_asserted", 1'b1, 1'b1, 1'b0, FE, C_ZERO);

        step("fe_timeout", 1'b0, 1'b0, 1'b0, FE, C_FE_W);
        for (int i = 0; i < 3; i++) step("fe_timeout", 1'b0, 1'b0, 1'b0, FE, C_FE_W);
        exp_to = 1'b1;
        for (int i = 0; i < 3; i++) step("fault_to", 1'b0, 1'b1, 1'b1, FT, C_ZERO);

        step("reset2", 1'b1, 1'b0, 1'b0, FE, C_ZERO);
        do_jump("pre_ill");
        opcode = 6'b111111;
        step("illegal", 1'b0, 1'b1, 1'b0, FE, C_FE_R);
        step("illegal", 1'b0, 1'b1, 1'b0, DE, C_DE);
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++) step("fault_ill", 1'b0, 1'b1, 1'b1, FT, C_ZERO);
        step("reset3", 1'b1, 1'b0, 1'b0, FE, C_ZERO);
        step("after_reset3", 1'b0, 1'b0, 1'b0, FE, C_FE_W);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
